// File: rtl/rx_record_deframer.sv
// ============================================================================
// Module   : rx_record_deframer
// Purpose  : Receive-side deframer for the FE-I4 8b10b link. Recognises
//            K28.7 (SOF), K28.5 (EOF) and K28.1 (idle) framing. Packs data
//            bytes MSB-first into 24-bit records for the record FIFO.
//            Reports framing, code and overflow errors.
// Options  : RX_ERR_COUNT_EN - build the saturating err_count counter
//            (otherwise err_count is tied to zero)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_record_deframer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_byte,
  input  logic             reset,
  input  logic             din_valid,
  input  logic [7:0]       din,
  input  logic             din_k,
  input  logic             code_err,
  input  logic             disp_err,
  input  logic             fifo_full,
  input  logic             err_clear,
  output logic [23:0]      fifo_data,
  output logic             fifo_write,
  output logic             in_frame,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_count,
  output logic             err_flag,
  output logic             overflow,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, B0 = 2'd1, B1 = 2'd2, B2 = 2'd3} state_t;

  localparam logic [7:0]       K_SOF    = 8'hFC;
  localparam logic [7:0]       K_EOF    = 8'hBC;
  localparam logic [7:0]       K_IDLE   = 8'h3C;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [7:0]         byte0_q, byte0_d;
  logic [7:0]         byte1_q, byte1_d;
  logic [23:0]        fifo_data_q, fifo_data_d;
  logic               fifo_write_q, fifo_write_d;
  logic               in_frame_q, in_frame_d;
  logic               frame_done_q, frame_done_d;
  logic [CNT_W-1:0]   frame_count_q, frame_count_d;
  logic               err_flag_q, err_flag_d;
  logic               overflow_q, overflow_d;
  logic               err_event;
  logic               ovf_event;

  // Next-state decode: one symbol per valid strobe; at most one error event.
  always_comb begin
    state_d       = state_q;
    byte0_d       = byte0_q;
    byte1_d       = byte1_q;
    fifo_data_d   = fifo_data_q;
    fifo_write_d  = 1'b0;
    in_frame_d    = in_frame_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    err_event     = 1'b0;
    ovf_event     = 1'b0;

    if (din_valid) begin
      if (code_err || disp_err) begin
        // Corrupt symbol: byte is ignored, any frame in progress is aborted
        err_event = 1'b1;
        if (state_q != IDLE) begin
          state_d    = IDLE;
          in_frame_d = 1'b0;
        end
      end else if (state_q == IDLE) begin
        if (din_k && din == K_SOF) begin
          state_d    = B0;
          in_frame_d = 1'b1;
        end else if (!(din_k && din == K_IDLE)) begin
          err_event = 1'b1;
        end
      end else if (!din_k) begin
        case (state_q)
          B0: begin
            byte0_d = din;
            state_d = B1;
          end
          B1: begin
            byte1_d = din;
            state_d = B2;
          end
          default: begin
            if (fifo_full) begin
              err_event = 1'b1;
              ovf_event = 1'b1;
            end else begin
              fifo_write_d = 1'b1;
              fifo_data_d  = {byte0_q, byte1_q, din};
            end
            state_d = B0;
          end
        endcase
      end else if (din == K_SOF) begin
        // SOF inside a frame: drop partial bytes and start over
        err_event = 1'b1;
        state_d   = B0;
      end else if (din == K_EOF) begin
        state_d    = IDLE;
        in_frame_d = 1'b0;
        if (state_q == B0) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + CNT_ONE;
        end else begin
          err_event = 1'b1;
        end
      end else begin
        err_event  = 1'b1;
        state_d    = IDLE;
        in_frame_d = 1'b0;
      end
    end

    // Clear has priority over a coincident event
    if (err_clear) begin
      err_flag_d = 1'b0;
      overflow_d = 1'b0;
    end else begin
      err_flag_d = err_flag_q | err_event;
      overflow_d = overflow_q | ovf_event;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_byte or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      byte0_q       <= '0;
      byte1_q       <= '0;
      fifo_data_q   <= '0;
      fifo_write_q  <= 1'b0;
      in_frame_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_flag_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte0_q       <= byte0_d;
      byte1_q       <= byte1_d;
      fifo_data_q   <= fifo_data_d;
      fifo_write_q  <= fifo_write_d;
      in_frame_q    <= in_frame_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      err_flag_q    <= err_flag_d;
      overflow_q    <= overflow_d;
    end
  end

  assign fifo_data   = fifo_data_q;
  assign fifo_write  = fifo_write_q;
  assign in_frame    = in_frame_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign err_flag    = err_flag_q;
  assign overflow    = overflow_q;

`ifdef RX_ERR_COUNT_EN
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // Saturating error-event counter.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clear) begin
      err_count_d = '0;
    end else if (err_event && err_count_q != '1) begin
      err_count_d = err_count_q + CNT_ONE;
    end
  end

  // Error counter register.
  always_ff @(posedge clk_byte or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

endmodule

`default_nettype wire
